serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that sequences a pair of half-adder cells, chained as one full-adder bit slice, to add two WIDTH-bit operands LSB-first, one bit per clock. It sits between a requester that presents operand pairs over a valid/ready handshake and a consumer that drains the result over a second valid/ready handshake. It trades throughput for area: one bit slice is reused WIDTH times instead of instantiating a WIDTH-bit ripple adder.

---
 rtl/serial_adder_ctrl.sv | 105 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice built from two half-adder
// cells is reused WIDTH times to add two operands LSB-first, one bit per clock.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift_a;
  logic [WIDTH-1:0] r_shift_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_s1;
  logic             w_c1;
  logic             w_sum;
  logic             w_c2;
  logic             w_carry_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_vec;

  // Half-adder cell 1 on the operand bits, cell 2 folds in the running carry.
  assign w_s1        = r_shift_a[0] ^ r_shift_b[0];
  assign w_c1        = r_shift_a[0] & r_shift_b[0];
  assign w_sum       = w_s1 ^ r_carry;
  assign w_c2        = w_s1 & r_carry;
  assign w_carry_nxt = w_c1 | w_c2;

  assign w_load    = start_valid && (r_state == S_IDLE);
  assign w_step    = (r_state == S_RUN);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_sum_vec = WIDTH'(w_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start_valid) w_state_nxt = S_RUN;
      S_RUN:  if (w_last)      w_state_nxt = S_DONE;
      S_DONE: if (res_ready)   w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // Sum bits enter at the MSB and walk right; shift-based insert keeps WIDTH=1 legal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift_a <= '0;
      r_shift_b <= '0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
    end else if (w_load) begin
      r_shift_a <= op_a;
      r_shift_b <= op_b;
      r_result  <= '0;
      r_carry   <= carry_in;
      r_cnt     <= '0;
    end else if (w_step) begin
      r_shift_a <= r_shift_a >> 1;
      r_shift_b <= r_shift_b >> 1;
      r_result  <= (r_result >> 1) | (w_sum_vec << (WIDTH - 1));
      r_carry   <= w_carry_nxt;
      r_cnt     <= r_cnt + CW'(1);
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign res_valid   = (r_state == S_DONE);
  assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
  assign result      = r_result;
  assign carry_out   = r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 (directed + random) and
// WIDTH=1 (random back-to-back), sharing one clock and reset.
module tb_serial_adder_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic       p8_sv, p8_sr, p8_ci, p8_rv, p8_rr, p8_co, p8_busy;
  logic [7:0] p8_a, p8_b, p8_res;
  logic       p1_sv, p1_sr, p1_ci, p1_rv, p1_rr, p1_co, p1_busy;
  logic [0:0] p1_a, p1_b, p1_res;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(p8_sv), .start_ready(p8_sr),
    .op_a(p8_a), .op_b(p8_b), .carry_in(p8_ci), .res_valid(p8_rv),
    .res_ready(p8_rr), .result(p8_res), .carry_out(p8_co), .busy(p8_busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(p1_sv), .start_ready(p1_sr),
    .op_a(p1_a), .op_b(p1_b), .carry_in(p1_ci), .res_valid(p1_rv),
    .res_ready(p1_rr), .result(p1_res), .carry_out(p1_co), .busy(p1_busy)
  );

  typedef struct {
    logic [8:0] sum;
    int         due;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1;
  logic prev8 = 1'b0;
  logic prev1 = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboards: push on an upcoming start handshake, pop on a result handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev8 = 1'b0;
    end else begin
      check_eq("excl8", {63'd0, p8_sr & p8_rv}, 64'd0);
      if (p8_sv && p8_sr)
        q8.push_back('{9'(p8_a) + 9'(p8_b) + 9'(p8_ci), cyc + 1 + 8});
      if (p8_rv && !prev8) begin
        if (q8.size() == 0) check_eq("sb8_empty", 64'd1, 64'd0);
        else                check_eq("lat8", 64'(cyc), 64'(q8[0].due));
      end
      if (p8_rv && p8_rr && q8.size() != 0) begin
        e8 = q8.pop_front();
        check_eq("res8", {55'd0, p8_co, p8_res}, {55'd0, e8.sum});
      end
      prev8 = p8_rv;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev1 = 1'b0;
    end else begin
      check_eq("excl1", {63'd0, p1_sr & p1_rv}, 64'd0);
      if (p1_sv && p1_sr)
        q1.push_back('{9'(p1_a) + 9'(p1_b) + 9'(p1_ci), cyc + 1 + 1});
      if (p1_rv && !prev1) begin
        if (q1.size() == 0) check_eq("sb1_empty", 64'd1, 64'd0);
        else                check_eq("lat1", 64'(cyc), 64'(q1[0].due));
      end
      if (p1_rv && p1_rr && q1.size() != 0) begin
        e1 = q1.pop_front();
        check_eq("res1", {62'd0, p1_co, p1_res}, {55'd0, e1.sum});
      end
      prev1 = p1_rv;
    end
  end

  // Returns #1 after the accepting edge with start_valid dropped.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    int k = 0;
    @(posedge clk); #1;
    p8_a = a; p8_b = b; p8_ci = ci; p8_sv = 1'b1;
    @(negedge clk);
    while (!p8_sr && k < 100) begin
      k++;
      @(negedge clk);
    end
    if (!p8_sr) check_eq("start8_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    p8_sv = 1'b0;
  endtask

  task automatic wait_idle8();
    int k = 0;
    @(negedge clk);
    while (!(p8_sr && !p8_busy) && k < 100) begin
      k++;
      @(negedge clk);
    end
    if (!p8_sr) check_eq("idle8_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_valid8();
    int k = 0;
    @(negedge clk);
    while (!p8_rv && k < 100) begin
      k++;
      @(negedge clk);
    end
    if (!p8_rv) check_eq("valid8_timeout", 64'd1, 64'd0);
  endtask

  task automatic run8(input int n);
    int last = -1;
    int k;
    for (int i = 0; i < n; i++) begin
      p8_a = 8'($urandom); p8_b = 8'($urandom); p8_ci = 1'($urandom); p8_sv = 1'b1;
      k = 0;
      @(negedge clk);
      while (!p8_sr && k < 100) begin
        k++;
        @(negedge clk);
      end
      if (!p8_sr) begin
        check_eq("run8_timeout", 64'd1, 64'd0);
        break;
      end
      if (last >= 0) check_eq("thru8", 64'(cyc - last), 64'd10);
      last = cyc;
      @(posedge clk); #1;
    end
    p8_sv = 1'b0;
  endtask

  task automatic run1(input int n);
    int last = -1;
    int k;
    for (int i = 0; i < n; i++) begin
      p1_a = 1'($urandom); p1_b = 1'($urandom); p1_ci = 1'($urandom); p1_sv = 1'b1;
      k = 0;
      @(negedge clk);
      while (!p1_sr && k < 100) begin
        k++;
        @(negedge clk);
      end
      if (!p1_sr) begin
        check_eq("run1_timeout", 64'd1, 64'd0);
        break;
      end
      if (last >= 0) check_eq("thru1", 64'(cyc - last), 64'd3);
      last = cyc;
      @(posedge clk); #1;
    end
    p1_sv = 1'b0;
  endtask

  logic [7:0] hold_res;
  logic       hold_co;

  initial begin
    p8_sv = 0; p8_a = '0; p8_b = '0; p8_ci = 0; p8_rr = 1;
    p1_sv = 0; p1_a = '0; p1_b = '0; p1_ci = 0; p1_rr = 1;

    // Reset and idle
    repeat (3) @(negedge clk);
    check_eq("rst_start_ready", {63'd0, p8_sr}, 64'd1);
    check_eq("rst_busy", {63'd0, p8_busy}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_start_ready", {63'd0, p8_sr}, 64'd1);
    check_eq("idle_res_valid", {63'd0, p8_rv}, 64'd0);
    check_eq("idle_busy", {63'd0, p8_busy}, 64'd0);
    check_eq("idle_result", {56'd0, p8_res}, 64'h00);
    check_eq("idle_carry", {63'd0, p8_co}, 64'd0);
    check_eq("idle1_start_ready", {63'd0, p1_sr}, 64'd1);

    // Basic add and carry chain
    start8(8'h3C, 8'h5A, 1'b0);
    @(negedge clk);
    check_eq("busy_after_e0", {63'd0, p8_busy}, 64'd1);
    wait_idle8();
    start8(8'hFF, 8'h00, 1'b1); wait_idle8();
    start8(8'hFF, 8'hFF, 1'b1); wait_idle8();

    // Backpressure with ignored start pulses
    p8_rr = 1'b0;
    start8(8'hA5, 8'h7E, 1'b1);
    wait_valid8();
    hold_res = p8_res;
    hold_co  = p8_co;
    check_eq("bp_result", {55'd0, hold_co, hold_res}, 64'h124);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      p8_sv = ~p8_sv; p8_a = 8'($urandom); p8_b = 8'($urandom); p8_ci = 1'($urandom);
      @(negedge clk);
      check_eq("bp_hold_res", {56'd0, p8_res}, {56'd0, hold_res});
      check_eq("bp_hold_co", {63'd0, p8_co}, {63'd0, hold_co});
      check_eq("bp_valid", {63'd0, p8_rv}, 64'd1);
      check_eq("bp_start_ready", {63'd0, p8_sr}, 64'd0);
    end
    @(posedge clk); #1;
    p8_sv = 1'b0; p8_rr = 1'b1;
    @(negedge clk);
    check_eq("bp_release_valid", {63'd0, p8_rv}, 64'd1);
    @(negedge clk);
    check_eq("bp_idle_ready", {63'd0, p8_sr}, 64'd1);
    check_eq("bp_idle_valid", {63'd0, p8_rv}, 64'd0);
    check_eq("bp_idle_busy", {63'd0, p8_busy}, 64'd0);

    // Reset in the middle of RUN
    start8(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", {63'd0, p8_sr}, 64'd1);
    check_eq("mid_rst_busy", {63'd0, p8_busy}, 64'd0);
    check_eq("mid_rst_result", {56'd0, p8_res}, 64'd0);
    q8.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("mid_rst_no_valid", {63'd0, p8_rv}, 64'd0);
    end
    start8(8'h01, 8'h01, 1'b0); wait_idle8();

    // Randomized back-to-back at both widths
    fork
      run8(1000);
      run1(1000);
    join
    repeat (15) @(negedge clk);
    check_eq("drain8", 64'(q8.size()), 64'd0);
    check_eq("drain1", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
